mgt_01_ireg_wb_arbiter: RTL and testbench
=========================================

Name: mgt_01_ireg_wb_arbiter

Overview:
Write-back arbiter and register scoreboard for the integer register file's single write port. It shares the write port between N_REQ execution units (ALU, MUL/DIV, LSU by default) using round-robin arbitration with valid/ready handshakes. It drives the registered write-enable, address and data into the register file, tracks in-flight destination registers, and raises a hazard to the issue stage.

Parameters:
N_REQ, 3, number of write-back requesters; 2..8.
AW, 5, register address width (32 integer registers).
DW, 32, data width.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  asynchronous reset, active-high.
clk_en_i  in  1  global clock enable; when low, all state is frozen.
req_valid_i  in  N_REQ  write-back request valid, one bit per unit.
req_addr_i  in  N_REQ*AW  destination register per unit; unit k occupies bits [k*AW +: AW].
req_data_i  in  N_REQ*DW  write data per unit; unit k occupies bits [k*DW +: DW].
req_ready_o  out  N_REQ  one-hot grant, combinational.
issue_valid_i  in  1  an instruction with destination issue_rd_i is issued this cycle.
issue_rd_i  in  AW  destination of the issuing instruction.
rs1_addr_i  in  AW  source 1 of the instruction in decode.
rs2_addr_i  in  AW  source 2 of the instruction in decode.
hazard_o  out  1  decode must stall, combinational.
rf_we_o  out  1  register file write enable, registered.
rf_waddr_o  out  AW  register file write address, registered.
rf_wdata_o  out  DW  register file write data, registered.
busy_o  out  2**AW  scoreboard bit vector; bit 0 is always 0.

Behaviour:
- Reset (async, rst_i=1):
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - busy_o=0.
  - Round-robin pointer rr_ptr=0.
- Arbitration (clk_en_i=1):
  - Scan requesters starting at rr_ptr and wrapping modulo N_REQ.
  - Grant the first unit with req_valid_i=1 and set its req_ready_o bit. At most one grant per cycle.
  - A transfer occurs when valid&ready. On the transfer edge, rr_ptr <= (winner+1) mod N_REQ.
  - With no transfer, rr_ptr holds.
- Requester rule: once valid is raised, the unit holds addr/data stable until ready. The arbiter never withdraws a grant within a cycle.
- Write stage latency is 1 cycle. A grant at edge t produces rf_we_o=1 with the winner's addr/data during cycle t+1.
  - If there is no grant, rf_we_o <= 0 and addr/data hold their previous values.
- X0 handling:
  - A request to address 0 is granted and consumed normally.
  - rf_we_o is registered as 0 for it, and the busy bit is untouched.
- Scoreboard:
  - An issue with issue_rd_i≠0 sets busy[issue_rd_i].
  - A grant for address a≠0 clears busy[a].
  - If set and clear target the same address in the same cycle, set wins (a new producer is in flight).
  - Issue to address 0 is ignored.
- Hazard (combinational) is the OR of:
  - RAW on rs1: busy[rs1_addr_i] and rs1_addr_i≠0. The same term applies to rs2.
  - WAW: issue_valid_i, busy[issue_rd_i], and issue_rd_i≠0.
  - Write-stage RAW (bypass disabled only): rf_we_o=1 and rf_waddr_o equals a nonzero rs1 or rs2. The RF read still returns the old value in that cycle.
- clk_en_i=0:
  - req_ready_o=0.
  - No state updates; issue is ignored.
  - rf_we_o holds its value; the RF is equally gated, so the pending write completes after re-enable.
- Reset mid-operation: all pending writes are dropped and the scoreboard is cleared. Units must re-present their requests.

Optional Feature:
Macro: MGT_01_WB_BYPASS_EN.
- Defined:
  - Adds ports fwd1_sel_o, fwd2_sel_o (1 bit each) and fwd_data_o (DW).
  - fwdN_sel_o=1 when rf_we_o=1 and rf_waddr_o equals a nonzero rsN; fwd_data_o=rf_wdata_o.
  - The write-stage RAW term is removed from hazard_o.
- Undefined: no forwarding ports, and the write-stage RAW term stalls decode for one cycle.

Test Plan:
- Reset mid-write: assert rst_i while rf_we_o=1 -> outputs go 0 immediately (async), busy_o=0, rr_ptr=0.
- Round-robin: all 3 valid continuously with addrs 5/6/7 and data 0xA/0xB/0xC -> grants 0,1,2,0 on consecutive cycles; rf_we_o=1 one cycle later with (5,0xA),(6,0xB),(7,0xC).
- X0 drop: unit 1 requests addr 0, data 0xDEAD -> req_ready_o=3'b010 that cycle; next cycle rf_we_o=0; busy_o unchanged.
- Scoreboard: issue rd=9; next cycle rs1=9 -> hazard_o=1; unit 2 write-back to 9 granted -> busy[9]=0 next edge. With bypass undefined, hazard_o stays 1 for one more cycle (write stage); with MGT_01_WB_BYPASS_EN, hazard_o=0 and fwd1_sel_o=1, fwd_data_o=write data.
- Set/clear collision: the same cycle issues rd=12 and grants a write-back to 12 -> busy[12]=1 after the edge.
- Clock enable: clk_en_i=0 for 3 cycles with all valid -> req_ready_o=0, rr_ptr, busy_o and rf_* frozen; on re-enable, arbitration resumes from the saved rr_ptr.

Source files
------------

// File: rtl/mgt_01_ireg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// mgt_01_ireg_wb_arbiter
//
// Purpose:
//   Write-back arbiter and register scoreboard for the integer register
//   file's single write port. The write port is shared between N_REQ
//   execution units using round-robin arbitration. The block registers the
//   winning write into the register file, tracks which destination registers
//   are still in flight, and raises a stall (hazard) to decode.
//
// Optional feature:
//   MGT_01_WB_BYPASS_EN - when defined, the write stage is forwarded to decode
//   through fwd1_sel_o / fwd2_sel_o / fwd_data_o. In that build the
//   write-stage RAW term no longer stalls decode.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active high
//   clk_en_i       global clock enable; when low all state is frozen
//   req_valid_i    [N_REQ]     write-back request valid per unit
//   req_addr_i     [N_REQ*AW]  destination per unit (unit k at [k*AW +: AW])
//   req_data_i     [N_REQ*DW]  write data per unit (unit k at [k*DW +: DW])
//   req_ready_o    [N_REQ]     one-hot grant, combinational
//   issue_valid_i  an instruction writing issue_rd_i issues this cycle
//   issue_rd_i     [AW]        destination of the issuing instruction
//   rs1_addr_i     [AW]        decode source 1
//   rs2_addr_i     [AW]        decode source 2
//   hazard_o       decode stall, combinational
//   fwd1_sel_o     (bypass build) forward write stage to source 1
//   fwd2_sel_o     (bypass build) forward write stage to source 2
//   fwd_data_o     (bypass build) forwarded data
//   rf_we_o        register file write enable, registered
//   rf_waddr_o     register file write address, registered
//   rf_wdata_o     register file write data, registered
//   busy_o         [2**AW]     scoreboard; bit 0 is always 0
//
// Handshake: a unit raises req_valid_i and holds its addr/data stable until
// it sees its req_ready_o bit. A transfer happens on a rising edge where
// valid & ready are both high. Ready is a pure function of the current
// valid vector and the round-robin pointer, so a grant is never withdrawn
// within a cycle.
// ---------------------------------------------------------------------------
module mgt_01_ireg_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*AW-1:0]   req_addr_i,
  input  logic [N_REQ*DW-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic                  issue_valid_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic [AW-1:0]         rs1_addr_i,
  input  logic [AW-1:0]         rs2_addr_i,
  output logic                  hazard_o,
`ifdef MGT_01_WB_BYPASS_EN
  output logic                  fwd1_sel_o,
  output logic                  fwd2_sel_o,
  output logic [DW-1:0]         fwd_data_o,
`endif
  output logic                  rf_we_o,
  output logic [AW-1:0]         rf_waddr_o,
  output logic [DW-1:0]         rf_wdata_o,
  output logic [(2**AW)-1:0]    busy_o
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREG = 2**AW;

  // State
  logic [PW-1:0]   rr_ptr_q;
  logic            rf_we_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [DW-1:0]   rf_wdata_q;
  logic [NREG-1:0] busy_q, busy_d;

  // Arbitration results
  logic             grant_any;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    cand;
  logic [N_REQ-1:0] grant_vec;
  logic [PW-1:0]    ptr_next;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  int               idx;

  // Round-robin scan starting at rr_ptr_q, wrapping modulo N_REQ.
  // No grant at all while the clock enable is low.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    idx       = 0;
    grant_vec = '0;
    if (clk_en_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= N_REQ) idx = idx - N_REQ;
        cand = idx[PW-1:0];
        if (!grant_any && req_valid_i[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    grant_vec[grant_idx] = grant_any;
  end

  assign req_ready_o = grant_vec;
  assign win_addr    = req_addr_i[grant_idx*AW +: AW];
  assign win_data    = req_data_i[grant_idx*DW +: DW];
  assign ptr_next    = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

  // Scoreboard next state: clear on write-back first, then set on issue so
  // that a same-cycle set/clear to one register leaves it busy (the newly
  // issued producer is still in flight).
  always_comb begin
    busy_d = busy_q;
    if (grant_any && (win_addr != '0)) busy_d[win_addr] = 1'b0;
    if (clk_en_i && issue_valid_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else if (clk_en_i) begin
      if (grant_any) begin
        rr_ptr_q   <= ptr_next;
        rf_waddr_q <= win_addr;
        rf_wdata_q <= win_data;
      end
      // Writes to x0 are consumed but never reach the register file.
      rf_we_q <= grant_any && (win_addr != '0);
      busy_q  <= busy_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign busy_o     = busy_q;

  // Hazard terms
  logic raw1, raw2, waw, ws_hit1, ws_hit2;

  assign raw1    = busy_q[rs1_addr_i] && (rs1_addr_i != '0);
  assign raw2    = busy_q[rs2_addr_i] && (rs2_addr_i != '0);
  assign waw     = issue_valid_i && busy_q[issue_rd_i] && (issue_rd_i != '0);
  // Write stage hits a source: the RF read in this cycle still returns the
  // old value, so it must either be forwarded or stalled.
  assign ws_hit1 = rf_we_q && (rs1_addr_i != '0) && (rf_waddr_q == rs1_addr_i);
  assign ws_hit2 = rf_we_q && (rs2_addr_i != '0) && (rf_waddr_q == rs2_addr_i);

`ifdef MGT_01_WB_BYPASS_EN
  assign fwd1_sel_o = ws_hit1;
  assign fwd2_sel_o = ws_hit2;
  assign fwd_data_o = rf_wdata_q;
  assign hazard_o   = raw1 || raw2 || waw;
`else
  assign hazard_o   = raw1 || raw2 || waw || ws_hit1 || ws_hit2;
`endif

endmodule

// File: tb/tb_mgt_01_ireg_wb_arbiter.sv
module tb_mgt_01_ireg_wb_arbiter;
  localparam int N_REQ = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic                clk_en_i;
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ*AW-1:0] req_addr_i;
  logic [N_REQ*DW-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic                issue_valid_i;
  logic [AW-1:0]       issue_rd_i, rs1_addr_i, rs2_addr_i;
  logic                hazard_o;
  logic                rf_we_o;
  logic [AW-1:0]       rf_waddr_o;
  logic [DW-1:0]       rf_wdata_o;
  logic [31:0]         busy_o;
`ifdef MGT_01_WB_BYPASS_EN
  logic                fwd1_sel_o, fwd2_sel_o;
  logic [DW-1:0]       fwd_data_o;
`endif

  int checks   = 0;
  int failures = 0;

  mgt_01_ireg_wb_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .hazard_o(hazard_o),
`ifdef MGT_01_WB_BYPASS_EN
    .fwd1_sel_o(fwd1_sel_o), .fwd2_sel_o(fwd2_sel_o), .fwd_data_o(fwd_data_o),
`endif
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .busy_o(busy_o)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_unit(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr_i[k*AW +: AW] = a;
    req_data_i[k*DW +: DW] = d;
  endtask

  task automatic idle();
    req_valid_i   = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    rs1_addr_i    = '0;
    rs2_addr_i    = '0;
  endtask

  task automatic test_reset();
    clk_en_i = 1'b1; req_addr_i = '0; req_data_i = '0; idle();
    rst_i = 1'b1;
    tick();
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata_o); end
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
    checks++; if (req_ready_o !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [4];
    logic [4:0]  exp_a [4];
    logic [31:0] exp_d [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{5'd5, 5'd6, 5'd7, 5'd5};
    exp_d = '{32'hA, 32'hB, 32'hC, 32'hA};
    set_unit(0, 5'd5, 32'hA); set_unit(1, 5'd6, 32'hB); set_unit(2, 5'd7, 32'hC);
    req_valid_i = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_ready_o !== exp_g[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready_o, exp_g[i]); end
      tick();
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, exp_a[i], exp_d[i]})
        begin failures++; $display("FAIL rr_write%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we_o, rf_waddr_o, rf_wdata_o, exp_a[i], exp_d[i]); end
    end
    req_valid_i = '0;
    tick();
    // No grant: enable drops, addr/data hold.
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd5, 32'hA})
      begin failures++; $display("FAIL rr_hold got=%b/%0d/%h exp=0/5/a", rf_we_o, rf_waddr_o, rf_wdata_o); end
  endtask

  task automatic test_x0();
    // rr_ptr is now 1
    set_unit(1, 5'd0, 32'hDEAD);
    req_valid_i = 3'b010;
    #1;
    checks++; if (req_ready_o !== 3'b010) begin failures++; $display("FAIL x0_ready got=%b exp=010", req_ready_o); end
    tick();
    req_valid_i = '0;
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL x0_we got=%b exp=0", rf_we_o); end
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL x0_busy got=%h exp=0", busy_o); end
  endtask

  task automatic test_scoreboard();
    // rr_ptr is now 2
    issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_valid_i = 1'b0; issue_rd_i = '0;
    checks++; if (busy_o !== 32'h0000_0200) begin failures++; $display("FAIL sb_set got=%h exp=00000200", busy_o); end
    rs1_addr_i = 5'd9;
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL sb_raw1 got=%b exp=1", hazard_o); end
    set_unit(2, 5'd9, 32'h1234);
    req_valid_i = 3'b100;
    #1;
    checks++; if (req_ready_o !== 3'b100) begin failures++; $display("FAIL sb_ready got=%b exp=100", req_ready_o); end
    tick();
    req_valid_i = '0;
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL sb_clear got=%h exp=0", busy_o); end
`ifdef MGT_01_WB_BYPASS_EN
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL sb_ws_hazard got=%b exp=0", hazard_o); end
    checks++; if ({fwd1_sel_o, fwd2_sel_o, fwd_data_o} !== {1'b1, 1'b0, 32'h1234})
      begin failures++; $display("FAIL sb_fwd got=%b/%b/%h exp=1/0/1234", fwd1_sel_o, fwd2_sel_o, fwd_data_o); end
`else
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL sb_ws_hazard got=%b exp=1", hazard_o); end
`endif
    tick();
    checks++; if (hazard_o !== 1'b0) begin failures++; $display("FAIL sb_hazard_done got=%b exp=0", hazard_o); end
    // rs2 RAW and WAW; rr_ptr is now 0
    rs1_addr_i = '0;
    issue_valid_i = 1'b1; issue_rd_i = 5'd3;
    tick();
    issue_valid_i = 1'b0; issue_rd_i = '0;
    rs2_addr_i = 5'd3;
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL sb_raw2 got=%b exp=1", hazard_o); end
    rs2_addr_i = '0; issue_valid_i = 1'b1; issue_rd_i = 5'd3;
    #1;
    checks++; if (hazard_o !== 1'b1) begin failures++; $display("FAIL sb_waw got=%b exp=1", hazard_o); end
    issue_valid_i = 1'b0; issue_rd_i = '0;
    set_unit(0, 5'd3, 32'h33);
    req_valid_i = 3'b001;
    #1;
    checks++; if (req_ready_o !== 3'b001) begin failures++; $display("FAIL sb_ready3 got=%b exp=001", req_ready_o); end
    tick();
    req_valid_i = '0;
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL sb_clear3 got=%h exp=0", busy_o); end
    tick();
  endtask

  task automatic test_collision();
    // rr_ptr is now 1
    issue_valid_i = 1'b1; issue_rd_i = 5'd12;
    set_unit(1, 5'd12, 32'hC0C0);
    req_valid_i = 3'b010;
    #1;
    checks++; if (req_ready_o !== 3'b010) begin failures++; $display("FAIL col_ready got=%b exp=010", req_ready_o); end
    tick();
    idle();
    checks++; if (busy_o !== 32'h0000_1000) begin failures++; $display("FAIL col_busy got=%h exp=00001000", busy_o); end
    checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd12}) begin failures++; $display("FAIL col_write got=%b/%0d exp=1/12", rf_we_o, rf_waddr_o); end
    // Retire the in-flight producer; rr_ptr is now 2
    set_unit(2, 5'd12, 32'h1212);
    req_valid_i = 3'b100;
    tick();
    req_valid_i = '0;
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL col_retire got=%h exp=0", busy_o); end
    tick();
  endtask

  task automatic test_clk_en();
    // rr_ptr is now 0; unit 1 alone wins, leaving rr_ptr at 2
    set_unit(1, 5'd17, 32'h17);
    req_valid_i = 3'b010;
    tick();
    checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd17}) begin failures++; $display("FAIL ce_pre got=%b/%0d exp=1/17", rf_we_o, rf_waddr_o); end
    set_unit(0, 5'd5, 32'hA); set_unit(1, 5'd6, 32'hB); set_unit(2, 5'd7, 32'hC);
    req_valid_i = 3'b111;
    clk_en_i = 1'b0;
    issue_valid_i = 1'b1; issue_rd_i = 5'd20;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready_o !== 3'b000) begin failures++; $display("FAIL ce_ready%0d got=%b exp=000", i, req_ready_o); end
      tick();
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd17, 32'h17})
        begin failures++; $display("FAIL ce_frozen%0d got=%b/%0d/%h exp=1/17/17", i, rf_we_o, rf_waddr_o, rf_wdata_o); end
      checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL ce_busy%0d got=%h exp=0", i, busy_o); end
    end
    clk_en_i = 1'b1;
    issue_rd_i = 5'd9;
    #1;
    checks++; if (req_ready_o !== 3'b100) begin failures++; $display("FAIL ce_resume got=%b exp=100", req_ready_o); end
    tick();
    issue_valid_i = 1'b0; issue_rd_i = '0;
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'hC})
      begin failures++; $display("FAIL ce_write got=%b/%0d/%h exp=1/7/c", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if (busy_o !== 32'h0000_0200) begin failures++; $display("FAIL ce_issue got=%h exp=00000200", busy_o); end
  endtask

  task automatic test_reset_mid_write();
    // valid still 111, rr_ptr 0: one more grant moves rr_ptr to 1
    #1;
    checks++; if (req_ready_o !== 3'b001) begin failures++; $display("FAIL rm_pre_ready got=%b exp=001", req_ready_o); end
    tick();
    checks++; if (rf_we_o !== 1'b1) begin failures++; $display("FAIL rm_pre_we got=%b exp=1", rf_we_o); end
    rst_i = 1'b1;
    #1;
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd0, 32'd0})
      begin failures++; $display("FAIL rm_async got=%b/%0d/%h exp=0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL rm_busy got=%h exp=0", busy_o); end
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 3'b001) begin failures++; $display("FAIL rm_ptr got=%b exp=001", req_ready_o); end
    tick();
    req_valid_i = '0;
    checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd5}) begin failures++; $display("FAIL rm_after got=%b/%0d exp=1/5", rf_we_o, rf_waddr_o); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_collision();
    test_clk_en();
    test_reset_mid_write();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
